// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite blitter and its pixel fetch.
package sprite_pkg;

  localparam int SPRITE_W        = 32;
  localparam int SPRITE_H        = 32;
  localparam int H_RES_DEFAULT   = 640;
  localparam int V_RES_DEFAULT   = 480;

  typedef logic [23:0] rgb_t;
  typedef rgb_t [SPRITE_W-1:0] sprite_t;

  localparam rgb_t TRANSPARENT_DEFAULT = 24'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WRITE,
    ST_DONE
  } blit_state_e;

endpackage

// File: rtl/sprite_pixel_mux.sv
// Combinational fetch of one pixel from the sprite bus, with optional horizontal flip.
module sprite_pixel_mux
  import sprite_pkg::*;
(
  input  sprite_t    sprite_i [0:SPRITE_H-1],
  input  logic [4:0] row_i,
  input  logic [4:0] col_i,
  input  logic       mirror_i,
  output rgb_t       pixel_o
);

  logic [4:0] elem_idx;

  // The leftmost pixel sits in packed element 31, so unmirrored reads index from the top.
  assign elem_idx = mirror_i ? col_i : (5'(SPRITE_W - 1) - col_i);
  assign pixel_o  = sprite_i[row_i][elem_idx];

endmodule

// File: rtl/sprite_blitter.sv
// Copies a 32x32 sprite into the frame buffer one opaque, on-screen pixel per write.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int   H_RES       = H_RES_DEFAULT,
  parameter int   V_RES       = V_RES_DEFAULT,
  parameter rgb_t TRANSPARENT = TRANSPARENT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  sprite_t     sprite [0:SPRITE_H-1],
  input  logic [9:0]  x_pos,
  input  logic [8:0]  y_pos,
  input  logic        mirror,
  input  logic        start,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [9:0]  wr_x,
  output logic [8:0]  wr_y,
  output logic [23:0] wr_rgb,
  output logic        busy,
  output logic        done
);

  blit_state_e state_q, state_d;
  logic [9:0]  pix_q, pix_d;      // {row, col}: col is the fast-moving field
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        mirror_q, mirror_d;
  logic [9:0]  wr_x_q, wr_x_d;
  logic [8:0]  wr_y_q, wr_y_d;
  rgb_t        wr_rgb_q, wr_rgb_d;

  logic [4:0]  row, col;
  rgb_t        pixel;
  logic [10:0] sx;
  logic [9:0]  sy;
  logic        skip;
  logic        last;

  assign row = pix_q[9:5];
  assign col = pix_q[4:0];

  sprite_pixel_mux u_pixel_mux (
    .sprite_i (sprite),
    .row_i    (row),
    .col_i    (col),
    .mirror_i (mirror_q),
    .pixel_o  (pixel)
  );

  // Widened adds so a sprite hanging off the right/bottom edge clips instead of wrapping.
  assign sx   = {1'b0, x_q} + 11'(col);
  assign sy   = {1'b0, y_q} + 10'(row);
  assign skip = (pixel == TRANSPARENT) || (sx >= 11'(H_RES)) || (sy >= 10'(V_RES));
  assign last = (pix_q == 10'h3FF);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d  = state_q;
    pix_d    = pix_q;
    x_d      = x_q;
    y_d      = y_q;
    mirror_d = mirror_q;
    wr_x_d   = wr_x_q;
    wr_y_d   = wr_y_q;
    wr_rgb_d = wr_rgb_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d      = x_pos;
          y_d      = y_pos;
          mirror_d = mirror;
          pix_d    = '0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (skip) begin
          pix_d   = pix_q + 10'd1;
          state_d = last ? ST_DONE : ST_SCAN;
        end else begin
          wr_x_d   = sx[9:0];
          wr_y_d   = sy[8:0];
          wr_rgb_d = pixel;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_ready) begin
          pix_d   = pix_q + 10'd1;
          state_d = last ? ST_DONE : ST_SCAN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      pix_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mirror_q <= 1'b0;
      wr_x_q   <= '0;
      wr_y_q   <= '0;
      wr_rgb_q <= '0;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mirror_q <= mirror_d;
      wr_x_q   <= wr_x_d;
      wr_y_q   <= wr_y_d;
      wr_rgb_q <= wr_rgb_d;
    end
  end

  assign wr_valid = (state_q == ST_WRITE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign wr_x     = wr_x_q;
  assign wr_y     = wr_y_q;
  assign wr_rgb   = wr_rgb_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: directed sprites, expected writes queued, monitor compares.
module tb_sprite_blitter;
  import sprite_pkg::*;

  logic        clk;
  logic        reset_n;
  sprite_t     sprite [0:SPRITE_H-1];
  logic [9:0]  x_pos;
  logic [8:0]  y_pos;
  logic        mirror;
  logic        start;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic [23:0] wr_rgb;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;
  logic [42:0] exp_q [$];

  sprite_blitter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sprite   (sprite),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .mirror   (mirror),
    .start    (start),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_rgb   (wr_rgb),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected write per accepted handshake.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_valid && wr_ready) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got x=%0d y=%0d rgb=%06h expected none", wr_x, wr_y, wr_rgb);
      end else begin
        check("write", {21'd0, wr_x, wr_y, wr_rgb}, {21'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_exp(input int x, input int y, input logic [23:0] rgb);
    exp_q.push_back({10'(x), 9'(y), rgb});
  endtask

  task automatic clear_sprite();
    for (int r = 0; r < SPRITE_H; r++) sprite[r] = '0;
  endtask

  // Pulses start for one cycle; returns at the negedge of cycle 1.
  task automatic kick(input int x, input int y, input logic mir);
    @(posedge clk);
    #1;
    x_pos  = 10'(x);
    y_pos  = 9'(y);
    mirror = mir;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_cycle1", {63'd0, busy}, 64'd1);
  endtask

  // Waits for done (bounded); exp_cyc < 0 skips the latency check.
  task automatic wait_done(input int exp_cyc);
    int k = 1;
    while (!done && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", k);
    end else if (exp_cyc >= 0) begin
      check("done_cycle", 64'(k), 64'(exp_cyc));
    end
    @(negedge clk);
    check("busy_after_done", {62'd0, busy, done}, 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!wr_valid && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("valid_seen", {63'd0, wr_valid}, 64'd1);
  endtask

  initial begin
    logic [42:0] held;
    int d0, w0;

    reset_n  = 1'b0;
    start    = 1'b0;
    x_pos    = '0;
    y_pos    = '0;
    mirror   = 1'b0;
    wr_ready = 1'b1;
    clear_sprite();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {21'd0, wr_valid, busy, done, wr_x, wr_y, wr_rgb}, 64'd0);
    #1 reset_n = 1'b1;

    // Single opaque pixel at row 3, column 17.
    clear_sprite();
    sprite[3][31-17] = 24'hFF0000;
    push_exp(117, 53, 24'hFF0000);
    d0 = done_cnt;
    kick(100, 50, 1'b0);
    wait_done(1026);
    check("single_done_count", 64'(done_cnt - d0), 64'd1);

    // Mirrored: element 14 becomes column 14.
    push_exp(114, 53, 24'hFF0000);
    kick(100, 50, 1'b1);
    wait_done(1026);

    // Fully transparent sprite: no writes, 1024 scan cycles.
    clear_sprite();
    w0 = wr_cnt;
    kick(300, 200, 1'b0);
    wait_done(1025);
    check("transparent_writes", 64'(wr_cnt - w0), 64'd0);

    // Backpressure: two pixels, first held off for several cycles.
    clear_sprite();
    sprite[0][31-0] = 24'h00FF00;
    sprite[1][31-5] = 24'h0000FF;
    push_exp(10, 20, 24'h00FF00);
    push_exp(15, 21, 24'h0000FF);
    w0 = wr_cnt;
    wr_ready = 1'b0;
    kick(10, 20, 1'b0);
    wait_valid();
    held = {wr_x, wr_y, wr_rgb};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {63'd0, wr_valid}, 64'd1);
      check("stall_data", {21'd0, wr_x, wr_y, wr_rgb}, {21'd0, held});
    end
    @(posedge clk);
    #1 wr_ready = 1'b1;
    wait_done(-1);
    check("backpressure_writes", 64'(wr_cnt - w0), 64'd2);

    // Clipping: fully opaque sprite at (630,470) leaves a 10x10 corner on screen.
    for (int r = 0; r < SPRITE_H; r++)
      for (int e = 0; e < SPRITE_W; e++)
        sprite[r][e] = {8'(r), 8'(e), 8'hA5};
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        push_exp(630 + c, 470 + r, {8'(r), 8'(31 - c), 8'hA5});
    w0 = wr_cnt;
    kick(630, 470, 1'b0);
    wait_done(1125);
    check("clip_writes", 64'(wr_cnt - w0), 64'd100);

    // Start while busy is ignored.
    clear_sprite();
    sprite[3][31-17] = 24'h123456;
    push_exp(217, 103, 24'h123456);
    d0 = done_cnt;
    kick(200, 100, 1'b0);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #1;
    x_pos = 10'd300;
    y_pos = 9'd300;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(-1);
    repeat (20) @(negedge clk);
    check("restart_ignored_busy", {63'd0, busy}, 64'd0);
    check("restart_done_count", 64'(done_cnt - d0), 64'd1);

    // Reset while a write is pending drops it.
    wr_ready = 1'b0;
    kick(200, 100, 1'b0);
    wait_valid();
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_midwrite", {21'd0, wr_valid, busy, done, wr_x, wr_y, wr_rgb}, 64'd0);
    exp_q.delete();
    #1;
    reset_n  = 1'b1;
    wr_ready = 1'b1;
    push_exp(217, 103, 24'h123456);
    kick(200, 100, 1'b0);
    wait_done(1026);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Sequential blitter that copies one 32x32, 24-bit sprite into the frame buffer at a given screen position. It sits directly downstream of the sprite ROM modules: the 32-row sprite bus is wired from the selected ROM, and the blitter emits one frame-buffer write per opaque, on-screen pixel. Writes use a valid/ready handshake. Transparent pixels and pixels outside the visible area are skipped.

## Interface
- `H_RES`, 640: visible width in pixels; writes with x ≥ H_RES are clipped.
- `V_RES`, 480: visible height in pixels; writes with y ≥ V_RES are clipped.
- `TRANSPARENT`, 24'd0: color value that is never written.
- `clk`  in  1: system clock.
- `reset_n`  in  1: reset, synchronous, active-low.
- `sprite`  in  [31:0][23:0] x [0:31]: sprite bus from the ROM; `sprite[r]` is row r (top = 0).
- `x_pos`  in  10: screen x of the sprite's top-left pixel.
- `y_pos`  in  9: screen y of the sprite's top-left pixel.
- `mirror`  in  1: when 1, flip the sprite horizontally.
- `start`  in  1: one-cycle request to blit; honored only in IDLE.
- `wr_valid`  out  1: write request to the frame buffer.
- `wr_ready`  in  1: frame buffer accepts the write.
- `wr_x`  out  10: write x coordinate.
- `wr_y`  out  9: write y coordinate.
- `wr_rgb`  out  24: write color, {r,g,b}.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when a blit completes.

## Operation
- Pixel addressing: column c of row r is `sprite[r][31-c]` (the leftmost pixel is packed element 31). With `mirror=1`, column c reads `sprite[r][c]`.
- `start` in IDLE latches `x_pos`, `y_pos` and `mirror`, clears row/col counters to (0,0), and moves to SCAN. `sprite` must stay stable while `busy` is high; the block does not latch it.
- FSM states: IDLE, SCAN, WRITE, DONE.
- SCAN evaluates pixel (r,c) and computes sx = x_pos + c and sy = y_pos + r using 11-bit and 10-bit adds, with no wrap.
  - If the pixel equals TRANSPARENT, or sx ≥ H_RES, or sy ≥ V_RES, advance the counter and stay in SCAN.
  - Otherwise, register wr_x = sx[9:0], wr_y = sy[8:0] and wr_rgb = pixel, then go to WRITE.
- WRITE: `wr_valid=1`, and `wr_x`/`wr_y`/`wr_rgb` hold stable until `wr_ready`. On `wr_ready`, advance the counter and return to SCAN.
- Counter order is column-major within a row: c goes 0→31, then r increments. After (31,31) is consumed (skipped in SCAN or accepted in WRITE), go to DONE instead of SCAN.
- DONE: `done=1` for one cycle, then go to IDLE.
- `start` is ignored while `busy`. A `start` in the cycle DONE→IDLE is also ignored.
- `reset_n=0` at any clock edge, including mid-blit:
  - state goes to IDLE;
  - counters and latched position go to 0;
  - `wr_valid`, `busy` and `done` go to 0;
  - `wr_x`, `wr_y` and `wr_rgb` go to 0.
  
  A pending write is dropped.

## Timing
- All outputs are registered, or decoded from the state register with no combinational path from inputs.
- `start` at cycle 0 puts the FSM in SCAN at cycle 1, with `busy=1` from cycle 1.
- Each skipped pixel costs 1 cycle.
- Each written pixel costs 1 SCAN cycle plus at least 1 WRITE cycle; with `wr_ready` tied high, that is exactly 2 cycles.
- Fully transparent or fully clipped sprite: `done` pulses at cycle 1025 (1024 SCAN cycles + DONE), and `busy` drops at cycle 1026.
- With N opaque on-screen pixels and `wr_ready=1`, `done` pulses at cycle 1025 + N.
- `wr_ready` is don't-care when `wr_valid=0`.

## Structure
- Shared package `sprite_pkg` holds:
  - `SPRITE_W=32`, `SPRITE_H=32`;
  - typedef `rgb_t` (logic [23:0]);
  - typedef `sprite_t` (the [31:0][23:0] row type);
  - the state enum `blit_state_e`;
  - `H_RES`/`V_RES` defaults.
- One sub-module is natural: `sprite_pixel_mux`, a combinational fetch of pixel (r,c,mirror) from the sprite bus.
- The FSM, counters and clipping stay in `sprite_blitter`.

## Test plan
- Single opaque pixel: sprite all 0 except `sprite[3][31-17]=24'hFF0000`, pos (100,50), `wr_ready=1` → exactly one write (117,53,FF0000); `done` at cycle 1026.
- Mirror: same sprite with `mirror=1` → one write at (114,53).
- Backpressure: two opaque pixels, `wr_ready` held low 5 cycles → `wr_valid` and data stay stable for those 5 cycles; the second write follows; the total write count is 2.
- Clipping: full opaque sprite at (630,470) → only x 630..639 and y 470..479 are written, i.e. 100 writes, none out of range.
- Start while busy: a second `start` mid-blit → ignored; exactly one `done`; write coordinates match the first position.
- Reset mid-write: `reset_n=0` while in WRITE → next cycle all outputs are 0 and the FSM is in IDLE; a new `start` blits normally.
